// File: rtl/snow64_ext_dat_acc_burst_ctrl.sv
// snow64_ext_dat_acc_burst_ctrl
//   Splits one 256-bit CPU line access into four 64-bit beats on a
//   valid/ready memory bus. Read beats are reassembled into a full line.
//   Only one line transaction is in flight, with at most one beat outstanding.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   in_req                CPU request strobe (taken only while idle)
//   in_access_type        0 = read, 1 = write
//   in_addr               line address (low 5 bits ignored)
//   in_data               write line
//   out_busy              transaction in progress
//   out_data              last completed read line
//   out_mem_req/we/addr/wdata   beat request toward memory
//   in_mem_ready          beat accepted when out_mem_req && in_mem_ready
//   in_mem_rvalid/rdata   read beat return
//   out_timeout           (SNOW64_EXT_DAT_ACC_BURST_CTRL_TIMEOUT_EN only)
//                         sticky watchdog flag
//
// Optional build macro: SNOW64_EXT_DAT_ACC_BURST_CTRL_TIMEOUT_EN adds an
// 8-bit watchdog that abandons a transaction stalled for 255 cycles.

module snow64_ext_dat_acc_burst_ctrl #(
    parameter int ADDR_WIDTH = 64,
    parameter int LINE_WIDTH = 256,
    parameter int BUS_WIDTH  = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_req,
    input  logic                  in_access_type,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic [LINE_WIDTH-1:0] in_data,
    output logic                  out_busy,
    output logic [LINE_WIDTH-1:0] out_data,
    output logic                  out_mem_req,
    output logic                  out_mem_we,
    output logic [ADDR_WIDTH-1:0] out_mem_addr,
    output logic [BUS_WIDTH-1:0]  out_mem_wdata,
`ifdef SNOW64_EXT_DAT_ACC_BURST_CTRL_TIMEOUT_EN
    output logic                  out_timeout,
`endif
    input  logic                  in_mem_ready,
    input  logic                  in_mem_rvalid,
    input  logic [BUS_WIDTH-1:0]  in_mem_rdata
);

    localparam int NUM_BEATS = LINE_WIDTH / BUS_WIDTH;
    localparam int BEAT_W    = $clog2(NUM_BEATS);
    localparam int LINE_OFFS = $clog2(LINE_WIDTH / 8);
    localparam int BEAT_OFFS = $clog2(BUS_WIDTH / 8);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NUM_BEATS - 1);

    typedef enum logic [1:0] {IDLE, WR_BEAT, RD_ADDR, RD_WAIT} state_t;

    state_t                           state;
    logic [ADDR_WIDTH-1:LINE_OFFS]    baseHi;
    logic [LINE_WIDTH-1:0]            wrLine;
    logic [LINE_WIDTH-1:0]            rdBuf;
    logic [BEAT_W-1:0]                beat;
    logic [BEAT_W-1:0]                beatNext;
    logic                             accept;

    // The byte offset inside the line is dropped here on purpose.
    logic unusedAddrLow;
    assign unusedAddrLow = &{1'b0, in_addr[LINE_OFFS-1:0]};

    assign beatNext = beat + 1'b1;
    assign accept   = out_mem_req && in_mem_ready;

    // Beat address: line base with the beat index spliced into the offset,
    // so beats wrap inside the line and never carry into the line bits.
    function automatic logic [ADDR_WIDTH-1:0] beatAddr(
        input logic [ADDR_WIDTH-1:LINE_OFFS] hi,
        input logic [BEAT_W-1:0]             b
    );
        return {hi, b, {BEAT_OFFS{1'b0}}};
    endfunction

`ifdef SNOW64_EXT_DAT_ACC_BURST_CTRL_TIMEOUT_EN
    localparam logic [7:0] WDOG_LAST = 8'd254;
    logic [7:0] wdog;
    logic       beatEvent;
    assign beatEvent = accept || (state == RD_WAIT && in_mem_rvalid);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            baseHi        <= '0;
            wrLine        <= '0;
            rdBuf         <= '0;
            beat          <= '0;
            out_busy      <= 1'b0;
            out_data      <= '0;
            out_mem_req   <= 1'b0;
            out_mem_we    <= 1'b0;
            out_mem_addr  <= '0;
            out_mem_wdata <= '0;
`ifdef SNOW64_EXT_DAT_ACC_BURST_CTRL_TIMEOUT_EN
            wdog          <= '0;
            out_timeout   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_req) begin
                        baseHi       <= in_addr[ADDR_WIDTH-1:LINE_OFFS];
                        wrLine       <= in_data;
                        beat         <= '0;
                        out_busy     <= 1'b1;
                        out_mem_req  <= 1'b1;
                        out_mem_we   <= in_access_type;
                        out_mem_addr <= beatAddr(in_addr[ADDR_WIDTH-1:LINE_OFFS], '0);
`ifdef SNOW64_EXT_DAT_ACC_BURST_CTRL_TIMEOUT_EN
                        wdog         <= '0;
                        out_timeout  <= 1'b0;
`endif
                        if (in_access_type) begin
                            state         <= WR_BEAT;
                            out_mem_wdata <= in_data[BUS_WIDTH-1:0];
                        end else begin
                            state <= RD_ADDR;
                        end
                    end
                end

                WR_BEAT: begin
                    if (accept) begin
                        if (beat == LAST_BEAT) begin
                            state       <= IDLE;
                            out_busy    <= 1'b0;
                            out_mem_req <= 1'b0;
                            out_mem_we  <= 1'b0;
                        end else begin
                            beat          <= beatNext;
                            out_mem_addr  <= beatAddr(baseHi, beatNext);
                            out_mem_wdata <= wrLine[BUS_WIDTH*int'(beatNext) +: BUS_WIDTH];
                        end
                    end
                end

                RD_ADDR: begin
                    if (accept) begin
                        state       <= RD_WAIT;
                        out_mem_req <= 1'b0;
                    end
                end

                RD_WAIT: begin
                    if (in_mem_rvalid) begin
                        rdBuf[BUS_WIDTH*int'(beat) +: BUS_WIDTH] <= in_mem_rdata;
                        if (beat == LAST_BEAT) begin
                            // Final beat goes straight into out_data alongside the buffer.
                            out_data <= {in_mem_rdata, rdBuf[LINE_WIDTH-BUS_WIDTH-1:0]};
                            state    <= IDLE;
                            out_busy <= 1'b0;
                        end else begin
                            beat         <= beatNext;
                            state        <= RD_ADDR;
                            out_mem_req  <= 1'b1;
                            out_mem_addr <= beatAddr(baseHi, beatNext);
                        end
                    end
                end

                default: state <= IDLE;
            endcase

`ifdef SNOW64_EXT_DAT_ACC_BURST_CTRL_TIMEOUT_EN
            // Placed after the case so an expiry overrides the FSM's choice.
            if (state != IDLE) begin
                if (beatEvent) begin
                    wdog <= '0;
                end else if (wdog == WDOG_LAST) begin
                    state       <= IDLE;
                    out_busy    <= 1'b0;
                    out_mem_req <= 1'b0;
                    out_mem_we  <= 1'b0;
                    out_timeout <= 1'b1;
                    wdog        <= '0;
                end else begin
                    wdog <= wdog + 1'b1;
                end
            end
`endif
        end
    end

endmodule
